// File: rtl/buffer_stream_ctrl.sv
// buffer_stream_ctrl
// Sequencer in front of the single-port Buffer RAM. Each start fills
// LENGTH_SIZE words from a valid/ready input stream into the Buffer, then
// drains them in address order to a valid/ready output stream. One done
// pulse follows the last drained word.
//
// Optional feature macro: BUFFER_CTRL_REPLAY_EN
//   When defined, adds the replay input. Holding replay high in the DONE
//   cycle re-drains the stored vector without refilling, so one set of
//   weights can serve several windows.
//
// Ports
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   start         begin a fill; only looked at in IDLE
//   replay        (BUFFER_CTRL_REPLAY_EN only) re-drain from DONE
//   in_valid/in_ready/in_data     input stream
//   buf_wr/buf_adr/buf_din        Buffer write enable, address, write data
//   buf_dout                      Buffer combinational read data
//   out_valid/out_ready/out_data  output stream (out_data = buf_dout)
//   busy          high while filling or draining
//   done          one-cycle pulse after the last word is drained
module buffer_stream_ctrl #(
    parameter int WORD_SIZE   = 32,
    parameter int LENGTH_SIZE = 10,
    // Bit count of LENGTH_SIZE (10 -> 4, 1 -> 1), matching the Buffer.
    localparam int ADR_SIZE   = $clog2(LENGTH_SIZE + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
`ifdef BUFFER_CTRL_REPLAY_EN
    input  logic                 replay,
`endif
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_SIZE-1:0] in_data,
    output logic                 buf_wr,
    output logic [ADR_SIZE-1:0]  buf_adr,
    output logic [WORD_SIZE-1:0] buf_din,
    input  logic [WORD_SIZE-1:0] buf_dout,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] out_data,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADR_SIZE-1:0] LAST = ADR_SIZE'(LENGTH_SIZE - 1);

    state_t              state, state_nxt;
    logic [ADR_SIZE-1:0] ptr, ptr_nxt;

    // The same pointer addresses the Buffer for both filling and draining.
    assign buf_adr  = ptr;
    assign buf_din  = in_data;
    assign out_data = buf_dout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        in_ready  = 1'b0;
        buf_wr    = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = FILL;
                    ptr_nxt   = '0;
                end
            end
            FILL: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                // in_ready is constant here, so every valid word is written.
                buf_wr   = in_valid;
                if (in_valid) begin
                    if (ptr == LAST) begin
                        ptr_nxt   = '0;
                        state_nxt = DRAIN;
                    end else begin
                        ptr_nxt = ptr + 1'b1;
                    end
                end
            end
            DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                // A stall holds ptr, which keeps out_data stable.
                if (out_ready) begin
                    if (ptr == LAST) begin
                        ptr_nxt   = '0;
                        state_nxt = DONE;
                    end else begin
                        ptr_nxt = ptr + 1'b1;
                    end
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
`ifdef BUFFER_CTRL_REPLAY_EN
                if (replay) begin
                    state_nxt = DRAIN;
                    ptr_nxt   = '0;
                end
`endif
            end
            default: begin
                state_nxt = IDLE;
                ptr_nxt   = '0;
            end
        endcase
    end

endmodule
